// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared peripheral map for the SoC bus.
// Holds the GPIO and GPIO_IRQ base addresses and the register offsets of the IRQ block.
package gpio_irq_pkg;
    localparam logic [7:0] GPIO_BASE     = 8'h00;
    localparam logic [7:0] GPIO_IRQ_BASE = 8'h04;
    typedef enum logic [1:0] {
        REG_MASK  = 2'd0,
        REG_FLAGS = 2'd1,
        REG_EDGE  = 2'd2,
        REG_SYNC  = 2'd3
    } irq_reg_e;
endpackage

// File: rtl/gpio_irq_if.sv
// gpio_irq_if: 8-bit peripheral bus.
// Signals: din (write data), address, w_en, r_en (strobes, sampled on posedge), dout (registered read data).
// Modports: master drives the strobes, address and data and reads dout; slave is the opposite side.
interface gpio_irq_if;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;
    modport master (output din, address, w_en, r_en, input dout);
    modport slave  (input din, address, w_en, r_en, output dout);
endinterface

// File: rtl/gpio_debounce.sv
// gpio_debounce: single-pin debouncer; level follows s2 only after it differs for DEBOUNCE_CYCLES edges.
// Ports: clk, rst (async, active-low), s2 (synchronised pin), level (accepted pin level).
module gpio_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic s2,
    output logic level
);
    localparam int W = DEBOUNCE_CYCLES > 2 ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (cnt == W'(DEBOUNCE_CYCLES - 1)) begin
            level <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/gpio_irq.sv
// gpio_irq: per-pin edge detector with sticky W1C flags, mask and a single registered interrupt.
// Ports: clk, rst (async, active-low), bus (gpio_irq_if slave: MASK/FLAGS/EDGE/SYNC at IRQ_ADDRESS+0..3),
//        pins (raw pin levels), irq (registered |(flags & mask)).
// Build option: define GPIO_IRQ_DEBOUNCE_EN to insert a gpio_debounce per pin after the synchroniser.
module gpio_irq
    import gpio_irq_pkg::*;
#(
`ifdef GPIO_IRQ_DEBOUNCE_EN
    parameter int         DEBOUNCE_CYCLES = 16,
`endif
    parameter logic [7:0] IRQ_ADDRESS     = GPIO_IRQ_BASE
) (
    input  logic       clk,
    input  logic       rst,
    gpio_irq_if.slave  bus,
    input  logic [7:0] pins,
    output logic       irq
);
    logic [7:0] s1, s2, level, prev, mask, flags, edge_sel;
    logic [7:0] hit, w1c, flags_n, rdata, off8;
    logic [1:0] arm_cnt;
    logic       armed, mapped;
    irq_reg_e   off;

`ifdef GPIO_IRQ_DEBOUNCE_EN
    for (genvar i = 0; i < 8; i++) begin : g_db
        gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .rst   (rst),
            .s2    (s2[i]),
            .level (level[i])
        );
    end
`else
    assign level = s2;
`endif

    always_comb begin
        off8    = bus.address - IRQ_ADDRESS;
        mapped  = off8 < 8'd4;
        off     = irq_reg_e'(off8[1:0]);
        // Hits are held off until the synchroniser has flushed its reset zeros,
        // so a pin already high at reset release is not seen as a rising edge.
        armed   = arm_cnt == 2'd3;
        hit     = armed ? ((edge_sel & level & ~prev) | (~edge_sel & ~level & prev)) : 8'h00;
        w1c     = (mapped && bus.w_en && off == REG_FLAGS) ? bus.din : 8'h00;
        // OR-ing hit after the clear lets a same-cycle edge survive its own W1C.
        flags_n = (flags & ~w1c) | hit;
        rdata   = off == REG_MASK  ? mask :
                  off == REG_FLAGS ? flags :
                  off == REG_EDGE  ? edge_sel : level;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1       <= 8'h00;
            s2       <= 8'h00;
            prev     <= 8'h00;
            arm_cnt  <= 2'd0;
            mask     <= 8'h00;
            flags    <= 8'h00;
            edge_sel <= 8'hFF;
            irq      <= 1'b0;
            bus.dout <= 8'h00;
        end else begin
            s1      <= pins;
            s2      <= s1;
            prev    <= level;
            arm_cnt <= armed ? arm_cnt : arm_cnt + 2'd1;
            flags   <= flags_n;
            irq     <= |(flags & mask);
            if (mapped && bus.w_en && off == REG_MASK)
                mask <= bus.din;
            if (mapped && bus.w_en && off == REG_EDGE)
                edge_sel <= bus.din;
            if (!mapped)
                bus.dout <= 8'h00;
            else if (bus.r_en)
                bus.dout <= rdata;
        end
    end
endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed plus random stimulus for gpio_irq, checked against a history-based reference model.
module tb_gpio_irq;
    import gpio_irq_pkg::*;

    localparam logic [7:0] A = GPIO_IRQ_BASE;
`ifdef GPIO_IRQ_DEBOUNCE_EN
    localparam int D = 4;
    localparam int EXTRA = D;
`else
    localparam int EXTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] pins = 8'h00;
    logic       irq;
    gpio_irq_if bus ();

`ifdef GPIO_IRQ_DEBOUNCE_EN
    gpio_irq #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .bus(bus), .pins(pins), .irq(irq));
`else
    gpio_irq dut (.clk(clk), .rst(rst), .bus(bus), .pins(pins), .irq(irq));
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // hist[j] is the pin vector sampled at edge j+1 after reset release;
    // lv[m] is the accepted level after edge m (lv[0] is the reset level).
    logic [7:0] hist[$];
    logic [7:0] lv[$];
    int         n;
    logic [7:0] m_mask, m_flags, m_edge, m_dout;
    logic       m_irq;

    function automatic logic [7:0] s2_after(int m);
        return (m >= 2) ? hist[m-2] : 8'h00;
    endfunction

    function automatic logic [7:0] lvl(int m);
        return (m >= 0) ? lv[m] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        lv.delete();
        lv.push_back(8'h00);
        n       = 0;
        m_mask  = 8'h00;
        m_flags = 8'h00;
        m_edge  = 8'hFF;
        m_dout  = 8'h00;
        m_irq   = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] cur, prv, hit, off, clr, nl;
        n++;
        hist.push_back(pins);
        cur = lvl(n-1);
        prv = lvl(n-2);
        hit = 8'h00;
        // The first three edges after release cannot flag anything.
        if (n >= 4)
            for (int i = 0; i < 8; i++)
                hit[i] = m_edge[i] ? (cur[i] && !prv[i]) : (!cur[i] && prv[i]);
        off = bus.address - A;
        if (off >= 8'd4)
            m_dout = 8'h00;
        else if (bus.r_en)
            case (off)
                8'd0:    m_dout = m_mask;
                8'd1:    m_dout = m_flags;
                8'd2:    m_dout = m_edge;
                default: m_dout = cur;
            endcase
        m_irq = |(m_flags & m_mask);
        clr = (bus.w_en && off == 8'd1) ? bus.din : 8'h00;
        m_flags = (m_flags & ~clr) | hit;
        if (bus.w_en && off == 8'd0) m_mask = bus.din;
        if (bus.w_en && off == 8'd2) m_edge = bus.din;
`ifdef GPIO_IRQ_DEBOUNCE_EN
        // A bit switches once the synchronised value has disagreed with it on D consecutive edges.
        nl = lvl(n-1);
        for (int i = 0; i < 8; i++) begin
            logic x, stable;
            x = s2_after(n-1)[i];
            stable = 1'b1;
            for (int j = 0; j < D; j++)
                if (s2_after(n-1-j)[i] != x) stable = 1'b0;
            if (stable) nl[i] = x;
        end
`else
        nl = s2_after(n);
`endif
        lv.push_back(nl);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        else model_reset();
        #1;
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
        chk("dout", bus.dout, m_dout);
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
        bus.w_en    = w;
        bus.r_en    = r;
        bus.address = a;
        bus.din     = d;
        tick();
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [7:0] a);
        cyc(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        bus.address = A;
        bus.din = 8'h00;
        model_reset();

        // 1: reset with all pins high, then release
        pins = 8'hFF;
        idle(3);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_dout", bus.dout, 8'h00);
        rst = 1'b1;
        idle(10);
        rd(A + 8'd1);
`ifndef GPIO_IRQ_DEBOUNCE_EN
        chk("t1_flags", bus.dout, 8'h00);
`endif
        rd(A + 8'd3);
        chk("t1_sync", bus.dout, 8'hFF);
        rd(A + 8'd2);
        chk("t1_edge", bus.dout, 8'hFF);

        // 2: rising edge on pin 0, latency and W1C
        pins = 8'h00;
        idle(4 + EXTRA);
        wr(A + 8'd1, 8'hFF);
        wr(A, 8'h01);
        wr(A + 8'd2, 8'hFF);
        pins = 8'h01;
        idle(3 + EXTRA);
        chk("t2_irq_e3", {7'b0, irq}, 8'h00);
        tick();
        chk("t2_irq_e4", {7'b0, irq}, 8'h01);
        rd(A + 8'd1);
        chk("t2_flags", bus.dout, 8'h01);
        wr(A + 8'd1, 8'h01);
        tick();
        chk("t2_irq_clr", {7'b0, irq}, 8'h00);
        rd(A + 8'd1);
        chk("t2_flags_clr", bus.dout, 8'h00);

        // 3: falling edge on pin 3 while masked, then unmask
        wr(A + 8'd2, 8'h00);
        wr(A, 8'h00);
        pins = 8'h09;
        idle(4 + EXTRA);
        pins = 8'h01;
        idle(4 + EXTRA);
        rd(A + 8'd1);
        chk("t3_flags", bus.dout, 8'h08);
        chk("t3_irq_masked", {7'b0, irq}, 8'h00);
        wr(A, 8'h08);
        tick();
        chk("t3_irq_unmask", {7'b0, irq}, 8'h01);

        // 4: hit and W1C on the same bit in the same cycle
        wr(A + 8'd1, 8'hFF);
        wr(A, 8'h00);
        wr(A + 8'd2, 8'hFF);
        idle(2);
        pins = 8'h05;
        idle(2 + EXTRA);
        wr(A + 8'd1, 8'h04);
        rd(A + 8'd1);
        chk("t4_set_wins", bus.dout, 8'h04);

        // 5: unmapped read, ignored SYNC write, async reset, re-arm
        rd(A + 8'd5);
        chk("t5_unmapped", bus.dout, 8'h00);
        wr(A + 8'd3, 8'hAA);
        rd(A);
        chk("t5_mask", bus.dout, 8'h00);
        rd(A + 8'd2);
        chk("t5_edge", bus.dout, 8'hFF);
        wr(A, 8'h04);
        tick();
        chk("t5_irq_pre", {7'b0, irq}, 8'h01);
        rd(A);
        chk("t5_dout_pre", bus.dout, 8'h04);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_irq", {7'b0, irq}, 8'h00);
        chk("t5_async_dout", bus.dout, 8'h00);
        tick();
        rst = 1'b1;
        idle(6);
        rd(A + 8'd1);
`ifndef GPIO_IRQ_DEBOUNCE_EN
        chk("t5_rearm", bus.dout, 8'h00);
`endif

`ifdef GPIO_IRQ_DEBOUNCE_EN
        // 6: glitch filtering and debounced latency
        pins = 8'h00;
        idle(12);
        wr(A + 8'd1, 8'hFF);
        wr(A, 8'hFF);
        wr(A + 8'd2, 8'hFF);
        pins = 8'h02;
        idle(3);
        pins = 8'h00;
        idle(15);
        rd(A + 8'd1);
        chk("t6_glitch", bus.dout, 8'h00);
        pins = 8'h02;
        idle(3 + D - 1);
        chk("t6_irq_early", {7'b0, irq}, 8'h00);
        tick();
        tick();
        chk("t6_irq", {7'b0, irq}, 8'h01);
        idle(4);
        pins = 8'h00;
        idle(12);
`endif

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
            cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                A + 8'($urandom_range(0, 5)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
